// File: rtl/vga_text_avl_writer.sv
// vga_text_avl_writer
//   Avalon-MM master that prints a character stream into the VGA text-mode
//   slave. It keeps a cursor on the COLS x ROWS grid, turns printable bytes
//   into single-lane VRAM writes, and interprets CR / LF / form-feed.
//   Form-feed blanks the whole screen. Separate requests write the slave's
//   control (colour) register.
//
// Ports
//   clk_i, reset_n_i        clock, synchronous active-low reset
//   char_valid_i/_data_i    character byte offer ([7] inverse, [6:0] glyph)
//   char_ready_o            character accepted this cycle
//   color_valid_i/_data_i   control-register write request and its value
//   color_ready_o           colour request accepted this cycle
//   avm_*                   Avalon-MM write master (addr, write, cs, byte_en,
//                           writedata, waitrequest)
//   cursor_col_o/_row_o     current cursor position
//   busy_o                  high while a transfer or screen clear is running
module vga_text_avl_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          CTRL_ADDR  = 600,
  parameter logic [7:0]  BLANK_CODE = 8'h20
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        char_valid_i,
  input  logic [7:0]  char_data_i,
  output logic        char_ready_o,
  input  logic        color_valid_i,
  input  logic [31:0] color_data_i,
  output logic        color_ready_o,
  output logic [9:0]  avm_addr_o,
  output logic        avm_write_o,
  output logic        avm_cs_o,
  output logic [3:0]  avm_byte_en_o,
  output logic [31:0] avm_writedata_o,
  input  logic        avm_waitrequest_i,
  output logic [6:0]  cursor_col_o,
  output logic [4:0]  cursor_row_o,
  output logic        busy_o
);

  localparam int LAST_WORD = ROWS * COLS / 4 - 1;

  typedef enum logic [1:0] {IDLE, WR_CHAR, CLEAR, WR_CTRL} state_e;

  state_e      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] data_q, data_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;

  logic        inIdle;
  logic        xferDone;
  logic        isCtrlChar;
  logic [4:0]  rowNext;
  logic [9:0]  charAddr;

  assign inIdle   = (state_q == IDLE);
  assign xferDone = avm_write_o & ~avm_waitrequest_i;

  // Ready is gated with reset so nothing looks acceptable while reset is held;
  // colour wins a tie with a character in the same cycle.
  assign color_ready_o = inIdle & reset_n_i;
  assign char_ready_o  = inIdle & reset_n_i & ~color_valid_i;

  // The bus strobe is simply "not idle": each non-idle state is one transfer
  // (or a run of back-to-back transfers for CLEAR).
  assign avm_write_o     = ~inIdle;
  assign avm_cs_o        = ~inIdle;
  assign busy_o          = ~inIdle;
  assign avm_addr_o      = addr_q;
  assign avm_byte_en_o   = be_q;
  assign avm_writedata_o = data_q;
  assign cursor_col_o    = col_q;
  assign cursor_row_o    = row_q;

  // Control codes are 0x00-0x1F and 0x7F with the inverse bit clear; anything
  // else, including every inverse byte, is a glyph.
  assign isCtrlChar = ~char_data_i[7] &
                      ((char_data_i[6:5] == 2'b00) || (char_data_i[6:0] == 7'h7F));

  // Row advance wraps to the top instead of scrolling.
  assign rowNext  = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

  // Four columns share one VRAM word; column 4*w+n lives in byte lane n.
  assign charAddr = 10'(row_q) * 10'(COLS / 4) + 10'(col_q[6:2]);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
    col_d   = col_q;
    row_d   = row_q;

    unique case (state_q)
      IDLE: begin
        if (color_valid_i) begin
          state_d = WR_CTRL;
          addr_d  = 10'(CTRL_ADDR);
          be_d    = 4'b1111;
          data_d  = color_data_i;
        end else if (char_valid_i) begin
          if (isCtrlChar) begin
            case (char_data_i[6:0])
              7'h0D: col_d = '0;
              7'h0A: begin
                col_d = '0;
                row_d = rowNext;
              end
              7'h0C: begin
                state_d = CLEAR;
                addr_d  = '0;
                be_d    = 4'b1111;
                data_d  = {4{BLANK_CODE}};
              end
              default: ;
            endcase
          end else begin
            state_d = WR_CHAR;
            addr_d  = charAddr;
            be_d    = 4'b0001 << col_q[1:0];
            data_d  = {4{char_data_i}};
          end
        end
      end

      WR_CHAR: begin
        if (xferDone) begin
          state_d = IDLE;
          if (col_q == 7'(COLS - 1)) begin
            col_d = '0;
            row_d = rowNext;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end

      WR_CTRL: begin
        if (xferDone) state_d = IDLE;
      end

      CLEAR: begin
        // The address register doubles as the clear counter.
        if (xferDone) begin
          if (addr_q == 10'(LAST_WORD)) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
          end else begin
            addr_d = addr_q + 10'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_text_avl_writer.sv
// Directed bench for vga_text_avl_writer: drives characters and colour
// requests, logs every completed Avalon write, and compares against
// hand-computed addresses, lanes and data.
module tb_vga_text_avl_writer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        charValid;
  logic [7:0]  charData;
  logic        charReady;
  logic        colorValid;
  logic [31:0] colorData;
  logic        colorReady;
  logic [9:0]  avmAddr;
  logic        avmWrite;
  logic        avmCs;
  logic [3:0]  avmBe;
  logic [31:0] avmData;
  logic        waitReq;
  logic [6:0]  curCol;
  logic [4:0]  curRow;
  logic        busy;

  int checks = 0;
  int fails = 0;
  int timeouts = 0;

  vga_text_avl_writer dut (
    .clk_i             (clk),
    .reset_n_i         (resetN),
    .char_valid_i      (charValid),
    .char_data_i       (charData),
    .char_ready_o      (charReady),
    .color_valid_i     (colorValid),
    .color_data_i      (colorData),
    .color_ready_o     (colorReady),
    .avm_addr_o        (avmAddr),
    .avm_write_o       (avmWrite),
    .avm_cs_o          (avmCs),
    .avm_byte_en_o     (avmBe),
    .avm_writedata_o   (avmData),
    .avm_waitrequest_i (waitReq),
    .cursor_col_o      (curCol),
    .cursor_row_o      (curRow),
    .busy_o            (busy)
  );

  // 10 ns clock; stimulus changes 2 ns after each rising edge.
  always #5 clk = ~clk;

  // Bus monitor on the falling edge: logs completed writes, counts write-high
  // cycles, and counts any change of address/data/lanes during a stall.
  logic [9:0]  logAddr[$];
  logic [3:0]  logBe[$];
  logic [31:0] logData[$];
  int          writeCycles = 0;
  int          stallBad = 0;
  logic        prevWrite = 1'b0;
  logic        prevWait = 1'b0;
  logic [9:0]  prevAddr = '0;
  logic [3:0]  prevBe = '0;
  logic [31:0] prevData = '0;

  always @(negedge clk) begin
    if (avmWrite) begin
      writeCycles++;
      if (prevWrite && prevWait &&
          (avmAddr !== prevAddr || avmBe !== prevBe || avmData !== prevData || avmCs !== 1'b1))
        stallBad++;
      if (!waitReq) begin
        logAddr.push_back(avmAddr);
        logBe.push_back(avmBe);
        logData.push_back(avmData);
      end
    end
    prevWrite = avmWrite;
    prevWait  = waitReq;
    prevAddr  = avmAddr;
    prevBe    = avmBe;
    prevData  = avmData;
  end

  int baseW;
  int baseCycles;
  int baseStall;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic mark();
    baseW      = logAddr.size();
    baseCycles = writeCycles;
    baseStall  = stallBad;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one character (isColor=0) or colour word (isColor=1) for exactly
  // the accepting edge, waiting a bounded time for ready.
  task automatic applyStimulus(input logic isColor, input logic [31:0] value);
    int n;
    n = 0;
    while (!(isColor ? colorReady : charReady) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) timeouts++;
    if (isColor) begin
      colorData  = value;
      colorValid = 1'b1;
    end else begin
      charData  = value[7:0];
      charValid = 1'b1;
    end
    step();
    colorValid = 1'b0;
    charValid  = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) timeouts++;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b0, {24'h0, b});
    waitIdle();
  endtask

  task automatic doReset();
    resetN = 1'b0;
    step();
    step();
    resetN = 1'b1;
    step();
  endtask

  initial begin
    int n;
    int seqBad;
    int readyBad;
    resetN     = 1'b0;
    charValid  = 1'b0;
    charData   = '0;
    colorValid = 1'b0;
    colorData  = '0;
    waitReq    = 1'b0;
    step();
    step();

    // Reset state: everything low, including both readies.
    checkOutput("rst write", 32'(avmWrite), 0);
    checkOutput("rst cs", 32'(avmCs), 0);
    checkOutput("rst addr", 32'(avmAddr), 0);
    checkOutput("rst be", 32'(avmBe), 0);
    checkOutput("rst data", avmData, 0);
    checkOutput("rst charReady", 32'(charReady), 0);
    checkOutput("rst colorReady", 32'(colorReady), 0);
    checkOutput("rst col", 32'(curCol), 0);
    checkOutput("rst row", 32'(curRow), 0);
    checkOutput("rst busy", 32'(busy), 0);
    resetN = 1'b1;
    #1;
    checkOutput("release charReady", 32'(charReady), 1);
    checkOutput("release colorReady", 32'(colorReady), 1);
    step();

    // 'A' at (0,0), no stall.
    mark();
    sendByte(8'h41);
    checkOutput("A count", 32'(logAddr.size() - baseW), 1);
    checkOutput("A addr", 32'(logAddr[baseW]), 0);
    checkOutput("A be", 32'(logBe[baseW]), 32'h1);
    checkOutput("A data", logData[baseW], 32'h41414141);
    checkOutput("A write cycles", 32'(writeCycles - baseCycles), 1);
    checkOutput("A col", 32'(curCol), 1);
    checkOutput("A row", 32'(curRow), 0);

    // Inverse 'B' at (1,0) with three stalled cycles.
    mark();
    waitReq = 1'b1;
    applyStimulus(1'b0, 32'hC2);
    step();
    step();
    step();
    checkOutput("stall cursor held", 32'(curCol), 1);
    waitReq = 1'b0;
    waitIdle();
    checkOutput("C2 count", 32'(logAddr.size() - baseW), 1);
    checkOutput("C2 addr", 32'(logAddr[baseW]), 0);
    checkOutput("C2 be", 32'(logBe[baseW]), 32'h2);
    checkOutput("C2 data", logData[baseW], 32'hC2C2C2C2);
    checkOutput("C2 write cycles", 32'(writeCycles - baseCycles), 4);
    checkOutput("C2 stable", 32'(stallBad - baseStall), 0);
    checkOutput("C2 col", 32'(curCol), 2);
    checkOutput("C2 row", 32'(curRow), 0);

    // One full row then 'Z' lands at the start of row 1.
    doReset();
    mark();
    for (int i = 0; i < 80; i++) sendByte(8'h30 + 8'(i % 64));
    sendByte(8'h5A);
    checkOutput("row wrap count", 32'(logAddr.size() - baseW), 81);
    checkOutput("row wrap col79 be", 32'(logBe[baseW + 79]), 32'h8);
    checkOutput("Z addr", 32'(logAddr[baseW + 80]), 20);
    checkOutput("Z be", 32'(logBe[baseW + 80]), 32'h1);
    checkOutput("Z data", logData[baseW + 80], 32'h5A5A5A5A);
    checkOutput("Z col", 32'(curCol), 1);
    checkOutput("Z row", 32'(curRow), 1);

    // CR then LF: cursor only, no bus traffic.
    mark();
    sendByte(8'h0D);
    checkOutput("CR col", 32'(curCol), 0);
    checkOutput("CR row", 32'(curRow), 1);
    sendByte(8'h0A);
    checkOutput("CRLF writes", 32'(logAddr.size() - baseW), 0);
    checkOutput("CRLF write cycles", 32'(writeCycles - baseCycles), 0);
    checkOutput("CRLF col", 32'(curCol), 0);
    checkOutput("CRLF row", 32'(curRow), 2);

    // A dropped control code leaves everything alone.
    mark();
    sendByte(8'h07);
    checkOutput("BEL writes", 32'(logAddr.size() - baseW), 0);
    checkOutput("BEL col", 32'(curCol), 0);

    // A full screen of characters wraps the cursor back to the origin.
    doReset();
    mark();
    for (int i = 0; i < 2400; i++) sendByte(8'h21 + 8'(i % 90));
    checkOutput("screen count", 32'(logAddr.size() - baseW), 2400);
    checkOutput("screen last addr", 32'(logAddr[baseW + 2399]), 599);
    checkOutput("screen last be", 32'(logBe[baseW + 2399]), 32'h8);
    checkOutput("screen last data", logData[baseW + 2399], 32'h5C5C5C5C);
    checkOutput("screen col", 32'(curCol), 0);
    checkOutput("screen row", 32'(curRow), 0);

    // Form-feed with random stalls after moving the cursor off the origin.
    sendByte(8'h41);
    checkOutput("pre-clear col", 32'(curCol), 1);
    mark();
    readyBad = 0;
    applyStimulus(1'b0, 32'h0C);
    n = 0;
    while (busy && n < 5000) begin
      if (charReady || colorReady) readyBad++;
      waitReq = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (n >= 5000) timeouts++;
    waitReq = 1'b0;
    seqBad = 0;
    for (int i = 0; i < 600; i++) begin
      if (logAddr[baseW + i] !== 10'(i) || logBe[baseW + i] !== 4'hF ||
          logData[baseW + i] !== 32'h20202020)
        seqBad++;
    end
    checkOutput("clear count", 32'(logAddr.size() - baseW), 600);
    checkOutput("clear sequence", 32'(seqBad), 0);
    checkOutput("clear ready low", 32'(readyBad), 0);
    checkOutput("clear stable", 32'(stallBad - baseStall), 0);
    checkOutput("clear col", 32'(curCol), 0);
    checkOutput("clear row", 32'(curRow), 0);

    // Colour and character offered together: colour goes first.
    mark();
    colorData  = 32'hDEADBEEF;
    colorValid = 1'b1;
    charData   = 8'h41;
    charValid  = 1'b1;
    #1;
    checkOutput("tie charReady", 32'(charReady), 0);
    checkOutput("tie colorReady", 32'(colorReady), 1);
    step();
    colorValid = 1'b0;
    n = 0;
    while (!charReady && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) timeouts++;
    step();
    charValid = 1'b0;
    waitIdle();
    checkOutput("tie count", 32'(logAddr.size() - baseW), 2);
    checkOutput("ctrl addr", 32'(logAddr[baseW]), 600);
    checkOutput("ctrl be", 32'(logBe[baseW]), 32'hF);
    checkOutput("ctrl data", logData[baseW], 32'hDEADBEEF);
    checkOutput("tie char addr", 32'(logAddr[baseW + 1]), 0);
    checkOutput("tie char be", 32'(logBe[baseW + 1]), 32'h1);
    checkOutput("tie char data", logData[baseW + 1], 32'h41414141);
    checkOutput("tie col", 32'(curCol), 1);

    // Reset in the middle of a clear.
    applyStimulus(1'b0, 32'h0C);
    for (int i = 0; i < 50; i++) step();
    checkOutput("mid-clear write", 32'(avmWrite), 1);
    checkOutput("mid-clear col", 32'(curCol), 1);
    resetN = 1'b0;
    step();
    checkOutput("abort write", 32'(avmWrite), 0);
    checkOutput("abort busy", 32'(busy), 0);
    checkOutput("abort col", 32'(curCol), 0);
    checkOutput("abort row", 32'(curRow), 0);
    checkOutput("abort charReady", 32'(charReady), 0);
    resetN = 1'b1;
    #1;
    checkOutput("post-abort charReady", 32'(charReady), 1);
    step();
    checkOutput("post-abort write", 32'(avmWrite), 0);

    checkOutput("bounded waits", 32'(timeouts), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_text_avl_writer.md
Name: vga_text_avl_writer

Overview:
- Avalon-MM master that drives the VGA text-mode slave's register block (VRAM words 0-599, control register 600) from a simple character stream.
- Keeps a hardware cursor on the 80x30 grid and turns each printable byte into a single-byte-lane VRAM write.
- Handles CR/LF/form-feed (clear screen) and control-register colour updates, so software or other hardware can print without computing VRAM addresses.

Parameters:
- COLS, 80, characters per row; must be a multiple of 4.
- ROWS, 30, rows on screen.
- CTRL_ADDR, 600, word address of the slave's control register.
- BLANK_CODE, 8'h20, glyph written by clear-screen.

Ports:
- CLK  in  1  system clock (50 MHz, same as slave).
- RESET_N  in  1  synchronous, active-low reset.
- CHAR_VALID  in  1  character byte offered.
- CHAR_DATA  in  8  [7] = inverse flag, [6:0] = glyph code.
- CHAR_READY  out  1  block accepts CHAR_DATA this cycle.
- COLOR_VALID  in  1  control-register write request.
- COLOR_DATA  in  32  value for the control register.
- COLOR_READY  out  1  block accepts COLOR_DATA this cycle.
- AVM_ADDR  out  10  word address.
- AVM_WRITE  out  1  write strobe.
- AVM_CS  out  1  chip select; always equal to AVM_WRITE.
- AVM_BYTE_EN  out  4  byte enables.
- AVM_WRITEDATA  out  32  write data.
- AVM_WAITREQUEST  in  1  slave stall.
- CURSOR_COL  out  7  current column, 0..COLS-1.
- CURSOR_ROW  out  5  current row, 0..ROWS-1.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET_N low at a CLK edge):
  - State goes to IDLE.
  - All outputs 0, except CHAR_READY and COLOR_READY, which go to 1 in the first cycle after reset is released.
  - Cursor goes to (0,0).
  - Any in-flight transfer is abandoned and AVM_WRITE drops on the next edge.
- States: IDLE, WR_CHAR, CLEAR, WR_CTRL.
- IDLE:
  - COLOR_READY = 1.
  - CHAR_READY = ~COLOR_VALID, so colour has priority and at most one request is accepted per cycle.
- Accepted colour request:
  - Goes to WR_CTRL.
  - Drives AVM_ADDR = CTRL_ADDR, AVM_BYTE_EN = 4'b1111, AVM_WRITEDATA = COLOR_DATA.
- Accepted character, decoded when CHAR_DATA[7] = 0:
  - 8'h0D (CR): CURSOR_COL <= 0 next cycle; no bus write; stay in IDLE.
  - 8'h0A (LF): CURSOR_COL <= 0; CURSOR_ROW <= row+1 (29 wraps to 0); no bus write; stay in IDLE.
  - 8'h0C (FF): go to CLEAR.
  - Other codes 0x00-0x1F and 0x7F: dropped; no change.
- Accepted character, any other byte (including every byte with bit 7 = 1): go to WR_CHAR.
  - AVM_ADDR = CURSOR_ROW*(COLS/4) + CURSOR_COL/4.
  - Lane n = CURSOR_COL[1:0]; AVM_BYTE_EN = one-hot 1<<n.
  - AVM_WRITEDATA = the byte replicated into all 4 lanes.
  - Lane n holds column 4*word+n.
- Bus timing:
  - Accept edge T; AVM_WRITE, AVM_CS and address/data/byte-enable become valid from T+1.
  - All of them are held constant while AVM_WAITREQUEST = 1.
  - A transfer completes on the first edge where AVM_WRITE = 1 and AVM_WAITREQUEST = 0.
  - Best-case throughput is one character per 2 cycles.
- WR_CHAR completion:
  - Cursor advances on the same edge.
  - Normally col+1; col 79 goes to col 0 with row+1; row 29 wraps to 0 (no scroll).
  - State returns to IDLE and AVM_WRITE drops.
- WR_CTRL completion: return to IDLE; cursor unchanged.
- CLEAR:
  - Internal 10-bit counter runs 0..ROWS*COLS/4-1 (599).
  - Each step is one write: AVM_ADDR = counter, AVM_BYTE_EN = 4'b1111, AVM_WRITEDATA = {4{BLANK_CODE}}.
  - The counter increments on each completion, so with no stall AVM_WRITE stays high for 600 back-to-back cycles.
  - On completion of address 599: cursor goes to (0,0), state goes to IDLE.
  - CHAR_READY and COLOR_READY stay 0 throughout.
- Invariants:
  - The control register is never touched by CLEAR.
  - AVM_ADDR never exceeds CTRL_ADDR.
  - Only one transfer is outstanding at a time.

Test Plan:
- Reset, then send 8'h41 with AVM_WAITREQUEST = 0: one write with ADDR 0, BE 4'b0001, DATA 32'h41414141, AVM_WRITE high exactly 1 cycle; cursor ends at (1,0).
- Then send 8'hC2 with AVM_WAITREQUEST held high 3 cycles: ADDR 0, BE 4'b0010, DATA 32'hC2C2C2C2 stable for all 4 write cycles; cursor ends at (2,0), advanced once only.
- From reset, send 80 printable chars then 'Z': the 81st write has ADDR 20, BE 4'b0001; cursor ends at (1,1). Then send CR, LF: no bus activity; cursor ends at (0,2).
- Send 2400 printable chars from (0,0): the last write has ADDR 599, BE 4'b1000; cursor wraps to (0,0).
- Send 8'h0C with waitrequest random: exactly 600 writes to ADDR 0..599 in order, each DATA 32'h20202020, BE 4'hF; CHAR_READY stays 0 until done; cursor ends at (0,0).
- Assert COLOR_VALID and CHAR_VALID in the same IDLE cycle: the control write (ADDR 600, BE 4'hF, DATA = COLOR_DATA) is issued first and the char is accepted afterwards. Pulse RESET_N low mid-CLEAR: AVM_WRITE = 0 on the next edge, cursor (0,0), CHAR_READY = 1 the cycle after release.
